// File: rtl/waterfall_row_writer_pkg.sv
// Shared waterfall definitions: FSM encoding and default geometry used by the
// row writer, the LCD driver and the framebuffer RAM.
package waterfall_pkg;

    localparam int DEF_WIDTH        = 320;
    localparam int DEF_HEIGHT       = 240;
    localparam int DEF_SAMPLE_WIDTH = 12;
    localparam int DEF_PIX_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH   = 17;

    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        FILL       = 2'd1,
        WAIT_BLANK = 2'd2,
        COMMIT     = 2'd3
    } wf_state_e;

    // Address width for a table of v entries, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/waterfall_row_writer_line_buffer.sv
// Single-row staging store: one write port, one registered read port (1-cycle latency).
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int DW    = 8,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Synchronous read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/waterfall_row_writer.sv
// Decimates ADC samples into waterfall rows, stages each row in a line buffer
// and copies it into the framebuffer during display blanking.
module waterfall_row_writer
    import waterfall_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int PIX_WIDTH    = DEF_PIX_WIDTH,
    parameter int DECIMATE     = 1,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]    sample_data,
    input  logic                       frame_blank,
    output logic                       fb_wen,
    output logic [ADDR_WIDTH-1:0]      fb_addr,
    output logic [PIX_WIDTH-1:0]       fb_wdata,
    output logic [$clog2(HEIGHT)-1:0]  top_row,
    output logic                       row_done,
    output logic                       clear_done,
    output logic                       overflow
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam int LB_AW = clog2_min1(WIDTH);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int DW    = $clog2(DECIMATE + 1);

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(WIDTH);
    localparam logic [CW-1:0]         COL_END   = CW'(WIDTH);
    localparam logic [CW-1:0]         COL_LAST  = CW'(WIDTH - 1);
    localparam logic [LB_AW-1:0]      LB_LAST   = LB_AW'(WIDTH - 1);
    localparam logic [DW-1:0]         DEC_LAST  = DW'(DECIMATE - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(HEIGHT - 1);

    wf_state_e               state_q,      state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q,    clr_cnt_d;
    logic [CW-1:0]           col_q,        col_d;
    logic [DW-1:0]           dec_cnt_q,    dec_cnt_d;
    logic [SAMPLE_WIDTH-1:0] acc_q,        acc_d;
    logic [ROW_W-1:0]        write_row_q,  write_row_d;
    logic [ADDR_WIDTH-1:0]   row_base_q,   row_base_d;
    logic                    pend_q,       pend_d;
    logic [LB_AW-1:0]        pend_col_q,   pend_col_d;
    logic                    last_q,       last_d;
    logic                    fb_wen_q,     fb_wen_d;
    logic [ADDR_WIDTH-1:0]   fb_addr_q,    fb_addr_d;
    logic [PIX_WIDTH-1:0]    fb_wdata_q,   fb_wdata_d;
    logic [ROW_W-1:0]        top_row_q,    top_row_d;
    logic                    row_done_q,   row_done_d;
    logic                    clear_done_q, clear_done_d;
    logic                    overflow_q,   overflow_d;

    logic                    lb_we_s;
    logic [LB_AW-1:0]        lb_waddr_s;
    logic [PIX_WIDTH-1:0]    lb_wdata_s;
    logic                    lb_re_s;
    logic [LB_AW-1:0]        lb_raddr_s;
    logic [PIX_WIDTH-1:0]    lb_rdata_s;
    logic [SAMPLE_WIDTH-1:0] samp_max_s;
    logic [ROW_W-1:0]        next_row_s;
    logic [ADDR_WIDTH-1:0]   next_base_s;

    line_buffer #(
        .DEPTH (WIDTH),
        .DW    (PIX_WIDTH),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we_s),
        .waddr (lb_waddr_s),
        .wdata (lb_wdata_s),
        .re    (lb_re_s),
        .raddr (lb_raddr_s),
        .rdata (lb_rdata_s)
    );

    // Next-state and registered-output computation for the whole writer.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        col_d        = col_q;
        dec_cnt_d    = dec_cnt_q;
        acc_d        = acc_q;
        write_row_d  = write_row_q;
        row_base_d   = row_base_q;
        pend_d       = 1'b0;
        pend_col_d   = pend_col_q;
        last_d       = 1'b0;
        fb_wen_d     = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        top_row_d    = top_row_q;
        row_done_d   = 1'b0;
        clear_done_d = clear_done_q | (state_q != CLEAR);
        overflow_d   = overflow_q;
        lb_we_s      = 1'b0;
        lb_waddr_s   = col_q[LB_AW-1:0];
        lb_re_s      = 1'b0;
        lb_raddr_s   = col_q[LB_AW-1:0];

        samp_max_s   = (sample_data > acc_q) ? sample_data : acc_q;
        lb_wdata_s   = samp_max_s[SAMPLE_WIDTH-1 -: PIX_WIDTH];
        next_row_s   = (write_row_q == ROW_LAST) ? '0 : write_row_q + ROW_W'(1);
        next_base_s  = (write_row_q == ROW_LAST) ? '0 : row_base_q + ROW_STEP;

        unique case (state_q)
            CLEAR: begin
                fb_wen_d   = 1'b1;
                fb_addr_d  = clr_cnt_q;
                fb_wdata_d = '0;
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = FILL;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            FILL: begin
                if (sample_valid) begin
                    if (dec_cnt_q == DEC_LAST) begin
                        lb_we_s   = 1'b1;
                        acc_d     = '0;
                        dec_cnt_d = '0;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            state_d = WAIT_BLANK;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        acc_d     = samp_max_s;
                        dec_cnt_d = dec_cnt_q + DW'(1);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            WAIT_BLANK: begin
                overflow_d = overflow_q | sample_valid;
                if (frame_blank) begin
                    col_d   = '0;
                    state_d = COMMIT;
                end else begin
                    state_d = WAIT_BLANK;
                end
            end
            COMMIT: begin
                overflow_d = overflow_q | sample_valid;
                if (last_q) begin
                    write_row_d = next_row_s;
                    row_base_d  = next_base_s;
                    top_row_d   = next_row_s;
                    row_done_d  = 1'b1;
                    col_d       = '0;
                    state_d     = FILL;
                end else if (frame_blank) begin
                    if (pend_q) begin
                        fb_wen_d   = 1'b1;
                        fb_addr_d  = row_base_q + ADDR_WIDTH'(pend_col_q);
                        fb_wdata_d = lb_rdata_s;
                        last_d     = (pend_col_q == LB_LAST);
                    end else begin
                        last_d = 1'b0;
                    end
                    if (col_q != COL_END) begin
                        lb_re_s    = 1'b1;
                        pend_d     = 1'b1;
                        pend_col_d = col_q[LB_AW-1:0];
                        col_d      = col_q + CW'(1);
                    end else begin
                        col_d = col_q;
                    end
                end else begin
                    // Blank ended with a read in flight: drop it and re-read that index later.
                    if (pend_q) begin
                        col_d = CW'(pend_col_q);
                    end else begin
                        col_d = col_q;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // All writer state and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            col_q        <= '0;
            dec_cnt_q    <= '0;
            acc_q        <= '0;
            write_row_q  <= '0;
            row_base_q   <= '0;
            pend_q       <= 1'b0;
            pend_col_q   <= '0;
            last_q       <= 1'b0;
            fb_wen_q     <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            top_row_q    <= '0;
            row_done_q   <= 1'b0;
            clear_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            col_q        <= col_d;
            dec_cnt_q    <= dec_cnt_d;
            acc_q        <= acc_d;
            write_row_q  <= write_row_d;
            row_base_q   <= row_base_d;
            pend_q       <= pend_d;
            pend_col_q   <= pend_col_d;
            last_q       <= last_d;
            fb_wen_q     <= fb_wen_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            top_row_q    <= top_row_d;
            row_done_q   <= row_done_d;
            clear_done_q <= clear_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fb_wen     = fb_wen_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign top_row    = top_row_q;
    assign row_done   = row_done_q;
    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_waterfall_row_writer.sv
// Self-checking bench for waterfall_row_writer on a 4x3 framebuffer, DECIMATE=2.
module tb_waterfall_row_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 8;

    typedef struct packed {
        logic [7:0][11:0] s;
        logic [3:0][7:0]  p;
    } row_vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          sample_valid;
    logic [11:0]   sample_data;
    logic          frame_blank;
    logic          fb_wen;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic [1:0]    top_row;
    logic          row_done;
    logic          clear_done;
    logic          overflow;

    row_vec_t vecs [4];
    wr_t      sb_q [$];
    int       vec_cnt = 0;
    int       err_cnt = 0;
    int       exp_row = 0;
    logic     prev_blank = 1'b1;

    waterfall_row_writer #(
        .WIDTH(W), .HEIGHT(H), .SAMPLE_WIDTH(12), .PIX_WIDTH(8),
        .DECIMATE(2), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .resetn(resetn), .sample_valid(sample_valid),
        .sample_data(sample_data), .frame_blank(frame_blank),
        .fb_wen(fb_wen), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .top_row(top_row), .row_done(row_done), .clear_done(clear_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every framebuffer write must match the next expected write.
    always @(negedge clk) begin
        if (resetn && fb_wen) begin
            if (clear_done) begin
                chk("write_outside_blank", 32'(prev_blank), 1);
            end
            if (sb_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", fb_addr, fb_wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("fb_addr", 32'(fb_addr), 32'(e.addr));
                chk("fb_wdata", 32'(fb_wdata), 32'(e.data));
            end
        end
        prev_blank = frame_blank;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fb_wen"}, 32'(fb_wen), 0);
        chk({tag, "_fb_addr"}, 32'(fb_addr), 0);
        chk({tag, "_fb_wdata"}, 32'(fb_wdata), 0);
        chk({tag, "_top_row"}, 32'(top_row), 0);
        chk({tag, "_row_done"}, 32'(row_done), 0);
        chk({tag, "_clear_done"}, 32'(clear_done), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    task automatic push_clear();
        for (int a = 0; a < W * H; a++) begin
            sb_q.push_back('{addr: AW'(a), data: 8'h00});
        end
    endtask

    task automatic wait_clear();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!clear_done && n < 100);
        chk("clear_done", 32'(clear_done), 1);
        chk("clear_writes_left", sb_q.size(), 0);
        chk("clear_top_row", 32'(top_row), 0);
        chk("clear_fb_wen_off", 32'(fb_wen), 0);
        tick();
    endtask

    task automatic send_row(input int v);
        for (int c = 0; c < W; c++) begin
            sb_q.push_back('{addr: AW'(exp_row * W + c), data: vecs[v].p[c]});
        end
        for (int i = 0; i < 2 * W; i++) begin
            sample_valid = 1'b1;
            sample_data  = vecs[v].s[i];
            tick();
        end
        sample_valid = 1'b0;
        sample_data  = 12'h000;
    endtask

    task automatic wait_row();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!row_done && n < 300);
        chk("row_done_seen", 32'(row_done), 1);
        exp_row = (exp_row + 1) % H;
        chk("top_row", 32'(top_row), exp_row);
        chk("row_writes_left", sb_q.size(), 0);
        @(negedge clk);
        chk("row_done_pulse", 32'(row_done), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0].s = {12'h020, 12'h010, 12'h000, 12'hFFF, 12'h150, 12'h200, 12'h3F0, 12'h100};
        vecs[0].p = {8'h02, 8'hFF, 8'h20, 8'h3F};
        vecs[1].s = {12'hABD, 12'hABC, 12'h001, 12'h00F, 12'h7FF, 12'h800, 12'h0AA, 12'h0AB};
        vecs[1].p = {8'hAB, 8'h00, 8'h80, 8'h0A};
        vecs[2].s = {12'h333, 12'h555, 12'h80F, 12'h7F0, 12'hFFF, 12'hFFF, 12'h456, 12'h123};
        vecs[2].p = {8'h55, 8'h80, 8'hFF, 8'h45};
        vecs[3].s = {12'hC01, 12'hC00, 12'h998, 12'h999, 12'h100, 12'h0FF, 12'h00F, 12'h010};
        vecs[3].p = {8'hC0, 8'h99, 8'h10, 8'h01};

        resetn       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 12'h000;
        frame_blank  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");

        push_clear();
        tick();
        resetn = 1'b1;
        // Samples during the clear must be ignored without raising overflow.
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data  = 12'hFFF;
            tick();
        end
        sample_valid = 1'b0;
        wait_clear();
        chk("clear_no_overflow", 32'(overflow), 0);

        // Four full rows: rows 0,1,2 then wrap to row 0; top_row 1,2,0,1.
        for (int v = 0; v < 4; v++) begin
            send_row(v);
            wait_row();
        end
        chk("no_overflow_yet", 32'(overflow), 0);

        // Blank drops mid-commit; copy must resume without skip or duplicate.
        begin
            int n = 0;
            int seen = 0;
            send_row(2);
            do begin
                @(negedge clk);
                if (fb_wen) seen++;
                n++;
            end while (seen < 2 && n < 100);
            chk("gap_start", seen, 2);
            tick();
            frame_blank = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (i > 0) chk("gap_fb_wen", 32'(fb_wen), 0);
            end
            tick();
            frame_blank = 1'b1;
            wait_row();
        end

        // Samples while waiting for blank are dropped and flag overflow.
        frame_blank = 1'b0;
        send_row(1);
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            sample_data  = 12'hFFF;
            tick();
        end
        sample_valid = 1'b0;
        @(negedge clk);
        chk("overflow_set", 32'(overflow), 1);
        tick();
        frame_blank = 1'b1;
        wait_row();
        send_row(3);
        wait_row();
        chk("overflow_sticky", 32'(overflow), 1);

        // Reset in the middle of a commit discards it and restarts the clear.
        begin
            int n = 0;
            send_row(0);
            do begin
                @(negedge clk);
                n++;
            end while (!fb_wen && n < 100);
            chk("midcommit_reached", 32'(fb_wen), 1);
            #2;
            resetn = 1'b0;
            #1;
            check_reset_vals("midrst");
            sb_q.delete();
            exp_row = 0;
            push_clear();
            repeat (2) @(posedge clk);
            #1;
            resetn = 1'b1;
            wait_clear();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
